lc_mem_ctrl: RTL and testbench

- Memory-side slave for the layer controller's memory port.
- Accepts 4-phase REQ/ACK single-word reads and writes, applies a fixed wait-state count, and backs them with an internal word-addressed SRAM array.
- Sits directly downstream of the layer controller: it consumes MEM_REQ_OUT, MEM_WRITE, MEM_ADDR_OUT and MEM_DATA_OUT, and produces MEM_ACK_IN and MEM_DATA_IN.

---
 rtl/lc_mem_ctrl.sv | 152 +++++++++++++++
 tb/tb_lc_mem_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/lc_mem_ctrl.sv
// lc_mem_ctrl: memory-side slave for the layer controller memory port.
// Handles a 4-phase REQ/ACK handshake and inserts a fixed number of wait states.
// Each access is a single-word read or write into an internal word-addressed SRAM.
// Out-of-range addresses and early REQ release are recorded as sticky error flags.
module lc_mem_ctrl #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 30,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  REQ_IN,
    input  logic                  WRITE_IN,
    input  logic [ADDR_WIDTH-1:0] ADDR_IN,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    output logic                  ACK_OUT,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic                  ADDR_ERR,
    output logic                  PROTO_ERR
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned AW1   = ADDR_WIDTH + 1;
    localparam logic [AW1-1:0]   DEPTH_EXT = AW1'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  ack_q;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  addr_err_q;
    logic                  proto_err_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  acc_en_c;
    logic                  acc_wr_c;
    logic [ADDR_WIDTH-1:0] acc_addr_c;
    logic [DATA_WIDTH-1:0] acc_data_c;
    logic                  in_range_c;
    logic [IDX_W-1:0]      idx_c;
    logic                  mem_we_c;

    // Select the access source: live inputs for a zero-wait access, latched request otherwise
    always_comb begin
        acc_en_c   = 1'b0;
        acc_wr_c   = wr_q;
        acc_addr_c = addr_q;
        acc_data_c = data_q;
        if (state_q == ST_IDLE && REQ_IN && WAIT_CYCLES == 0) begin
            acc_en_c   = 1'b1;
            acc_wr_c   = WRITE_IN;
            acc_addr_c = ADDR_IN;
            acc_data_c = DATA_IN;
        end else if (state_q == ST_WAIT && cnt_q == CNT_ONE) begin
            acc_en_c = 1'b1;
        end
    end

    // Full-width range check; the array index is only meaningful once it passes
    always_comb begin
        in_range_c = ({1'b0, acc_addr_c} < DEPTH_EXT);
        idx_c      = acc_addr_c[IDX_W-1:0];
        mem_we_c   = acc_en_c && acc_wr_c && in_range_c;
    end

    // SRAM write port; the array has no reset and keeps its contents across RESET
    always_ff @(posedge CLK) begin
        if (mem_we_c && !RESET) begin
            mem[idx_c] <= acc_data_c;
        end
    end

    // Handshake FSM, wait counter, read data and sticky error flags
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            ack_q       <= 1'b0;
            dout_q      <= '0;
            addr_err_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            if (acc_en_c) begin
                if (!in_range_c) begin
                    addr_err_q <= 1'b1;
                end
                if (!acc_wr_c) begin
                    dout_q <= in_range_c ? mem[idx_c] : '0;
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (REQ_IN) begin
                        wr_q   <= WRITE_IN;
                        addr_q <= ADDR_IN;
                        data_q <= DATA_IN;
                        cnt_q  <= CNT_LOAD;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= ST_ACK;
                            ack_q   <= 1'b1;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!REQ_IN) begin
                        proto_err_q <= 1'b1;
                    end
                    if (cnt_q == CNT_ONE) begin
                        state_q <= ST_ACK;
                        ack_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_ACK: begin
                    if (!REQ_IN) begin
                        ack_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ACK_OUT   = ack_q;
    assign DATA_OUT  = dout_q;
    assign ADDR_ERR  = addr_err_q;
    assign PROTO_ERR = proto_err_q;

endmodule

// File: tb/tb_lc_mem_ctrl.sv
// Testbench for lc_mem_ctrl: two instances (2 wait states, 0 wait states)
// checked against a behavioural array model with directed and random accesses.
module tb_lc_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst   [2];
    logic        req   [2];
    logic        wr    [2];
    logic [29:0] addr  [2];
    logic [31:0] wdata [2];
    logic        ack   [2];
    logic [31:0] rdata [2];
    logic        aerr  [2];
    logic        perr  [2];

    logic [31:0] mem_m    [2][256];
    logic [31:0] exp_dout [2];
    logic        aerr_m   [2];
    logic        perr_m   [2];
    int          waits    [2] = '{2, 0};

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    lc_mem_ctrl #(.WAIT_CYCLES(2)) u_dut_w2 (
        .CLK(clk), .RESET(rst[0]), .REQ_IN(req[0]), .WRITE_IN(wr[0]),
        .ADDR_IN(addr[0]), .DATA_IN(wdata[0]), .ACK_OUT(ack[0]),
        .DATA_OUT(rdata[0]), .ADDR_ERR(aerr[0]), .PROTO_ERR(perr[0])
    );

    lc_mem_ctrl #(.WAIT_CYCLES(0)) u_dut_w0 (
        .CLK(clk), .RESET(rst[1]), .REQ_IN(req[1]), .WRITE_IN(wr[1]),
        .ADDR_IN(addr[1]), .DATA_IN(wdata[1]), .ACK_OUT(ack[1]),
        .DATA_OUT(rdata[1]), .ADDR_ERR(aerr[1]), .PROTO_ERR(perr[1])
    );

    task automatic check(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s dut%0d observed=0x%08h expected=0x%08h", tag, i, obs, exp);
        end
    endtask

    // One complete 4-phase access with latency, data, flag and hold checks
    task automatic access(input int i, input bit w, input logic [29:0] a,
                          input logic [31:0] d, input int hold);
        int n;
        bit got;
        bit inr;
        @(negedge clk);
        req[i] = 1'b1; wr[i] = w; addr[i] = a; wdata[i] = d;
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (ack[i] === 1'b1) got = 1'b1;
            else begin
                wr[i]    = 1'($urandom);
                addr[i]  = 30'($urandom);
                wdata[i] = $urandom;
            end
        end
        inr = (a < 30'd256);
        if (!inr) aerr_m[i] = 1'b1;
        else if (w) mem_m[i][a[7:0]] = d;
        if (!w) exp_dout[i] = inr ? mem_m[i][a[7:0]] : 32'h0;
        check("ack_latency", i, 32'(n), 32'(waits[i] + 1));
        check("data_out", i, rdata[i], exp_dout[i]);
        check("addr_err", i, 32'(aerr[i]), 32'(aerr_m[i]));
        check("proto_err", i, 32'(perr[i]), 32'(perr_m[i]));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("ack_hold", i, 32'(ack[i]), 32'd1);
            check("data_hold", i, rdata[i], exp_dout[i]);
        end
        @(negedge clk);
        req[i] = 1'b0;
        @(posedge clk); #1;
        check("ack_fall", i, 32'(ack[i]), 32'd0);
    endtask

    initial begin
        logic [31:0] saved;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; req[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
            exp_dout[i] = '0; aerr_m[i] = 1'b0; perr_m[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_ack", i, 32'(ack[i]), 32'd0);
            check("rst_data", i, rdata[i], 32'd0);
            check("rst_aerr", i, 32'(aerr[i]), 32'd0);
            check("rst_perr", i, 32'(perr[i]), 32'd0);
        end
        @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0;

        // Fill both arrays so every later read has a known reference value
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 256; a++)
                access(i, 1'b1, 30'(a), $urandom, 0);

        // Write then read with two wait states
        access(0, 1'b1, 30'h05, 32'hDEADBEEF, 0);
        access(0, 1'b0, 30'h05, 32'h0, 1);
        check("tp_readback", 0, rdata[0], 32'hDEADBEEF);

        // Zero wait states, REQ held for 5 cycles
        access(1, 1'b0, 30'h0, 32'h0, 5);

        // Out-of-range accesses, no aliasing onto low addresses
        saved = mem_m[0][0];
        access(0, 1'b1, 30'h100, 32'h1234, 0);
        check("tp_addr_err", 0, 32'(aerr[0]), 32'd1);
        access(0, 1'b0, 30'h000, 32'h0, 0);
        check("tp_no_alias", 0, rdata[0], saved);
        access(0, 1'b0, 30'h100, 32'h0, 0);
        check("tp_oor_read", 0, rdata[0], 32'h0);
        access(0, 1'b0, 30'h05, 32'h0, 0);
        access(0, 1'b0, 30'h3FFFFF05, 32'h0, 0);
        check("tp_oor_high", 0, rdata[0], 32'h0);

        // Protocol violation: REQ dropped one cycle into WAIT
        @(negedge clk);
        req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 30'h09; wdata[0] = 32'hCAFEF00D;
        @(posedge clk); #1;
        check("pv_edge1_ack", 0, 32'(ack[0]), 32'd0);
        @(negedge clk);
        req[0] = 1'b0;
        @(posedge clk); #1;
        check("pv_perr", 0, 32'(perr[0]), 32'd1);
        check("pv_edge2_ack", 0, 32'(ack[0]), 32'd0);
        @(posedge clk); #1;
        check("pv_ack_pulse", 0, 32'(ack[0]), 32'd1);
        @(posedge clk); #1;
        check("pv_ack_end", 0, 32'(ack[0]), 32'd0);
        perr_m[0] = 1'b1;
        mem_m[0][9] = 32'hCAFEF00D;
        access(0, 1'b0, 30'h09, 32'h0, 0);

        // Reset during WAIT of a write: the pending write is lost
        access(0, 1'b1, 30'h07, 32'hAAAA0000, 0);
        @(negedge clk);
        req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 30'h07; wdata[0] = 32'h55555555;
        @(posedge clk); #1;
        @(negedge clk);
        rst[0] = 1'b1; req[0] = 1'b0;
        #1;
        check("mr_ack", 0, 32'(ack[0]), 32'd0);
        check("mr_perr", 0, 32'(perr[0]), 32'd0);
        check("mr_aerr", 0, 32'(aerr[0]), 32'd0);
        aerr_m[0] = 1'b0; perr_m[0] = 1'b0; exp_dout[0] = '0;
        @(negedge clk);
        rst[0] = 1'b0;
        access(0, 1'b0, 30'h07, 32'h0, 0);
        check("mr_keep_old", 0, rdata[0], 32'hAAAA0000);

        // Reset while ACK is high clears it asynchronously
        @(negedge clk);
        req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 30'h07;
        repeat (3) @(posedge clk);
        #1;
        check("ra_ack_high", 0, 32'(ack[0]), 32'd1);
        @(negedge clk);
        rst[0] = 1'b1; req[0] = 1'b0;
        #1;
        check("ra_ack_low", 0, 32'(ack[0]), 32'd0);
        check("ra_data_low", 0, rdata[0], 32'd0);
        exp_dout[0] = '0;
        @(negedge clk);
        rst[0] = 1'b0;

        // Back-to-back writes then reads
        for (int k = 0; k < 4; k++) access(0, 1'b1, 30'(k), 32'((k + 1) * 32'h11), 0);
        for (int k = 0; k < 4; k++) begin
            access(0, 1'b0, 30'(k), 32'h0, 0);
            check("b2b_read", 0, rdata[0], 32'((k + 1) * 32'h11));
        end

        // Random traffic on both instances
        for (int n = 0; n < 300; n++) begin
            int i;
            int r;
            logic [29:0] a;
            i = int'($urandom_range(1, 0));
            r = int'($urandom_range(9, 0));
            if (r < 8)       a = 30'($urandom_range(255, 0));
            else if (r == 8) a = 30'($urandom_range(271, 256));
            else             a = 30'($urandom);
            access(i, 1'($urandom), a, $urandom, int'($urandom_range(2, 0)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
